// File: rtl/jam_pkg.sv
// Shared widths, lock-state encoding and round-robin index helper for the jam cost arbiter.
// Widths match the 8x8 worker/job cost table: 3-bit indices, 7-bit costs, up to 8 engines.
package jam_pkg;

  localparam int JAM_IDX_W   = 3;
  localparam int JAM_COST_W  = 7;
  localparam int JAM_MAX_REQ = 8;

  typedef enum logic {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } lock_state_e;

  function automatic logic [JAM_IDX_W-1:0] jam_inc_mod(input logic [JAM_IDX_W-1:0] idx,
                                                       input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + JAM_IDX_W'(1);
  endfunction

endpackage

// File: rtl/jam_rr_picker.sv
// Combinational round-robin one-hot picker: rotate by rr_ptr, keep lowest set bit, rotate back.
// force_en restricts the grant to force_id alone (no grant if that requester is idle).
module jam_rr_picker
  import jam_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]      req,
  input  logic [JAM_IDX_W-1:0] rr_ptr,
  input  logic                 force_en,
  input  logic [JAM_IDX_W-1:0] force_id,
  output logic [NREQ-1:0]      grant
);

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] pick;

  always_comb begin
    rot   = NREQ'({req, req} >> rr_ptr);
    pick  = rot & (~rot + ONE);
    grant = NREQ'({pick, pick} >> (NREQ - int'(rr_ptr)));
    if (force_en) begin
      for (int i = 0; i < NREQ; i++) begin
        grant[i] = req[i] && (force_id == JAM_IDX_W'(i));
      end
    end
  end

endmodule

// File: rtl/jam_cost_arbiter.sv
// Shares the cost-ROM read port among NREQ engines: round-robin grants, optional owner lock.
// Fire-to-response latency ROM_LAT+2, one read per cycle, responses in order with no backpressure.
module jam_cost_arbiter
  import jam_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int ROM_LAT  = 0,
  parameter int LOCK_MAX = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_lock,
  input  logic [3*NREQ-1:0]     req_w,
  input  logic [3*NREQ-1:0]     req_j,
  output logic [NREQ-1:0]       req_ready,
  output logic [JAM_IDX_W-1:0]  W,
  output logic [JAM_IDX_W-1:0]  J,
  input  logic [JAM_COST_W-1:0] Cost,
  output logic                  rsp_valid,
  output logic [JAM_IDX_W-1:0]  rsp_id,
  output logic [JAM_COST_W-1:0] rsp_cost
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  lock_state_e                   state_q, state_d;
  logic [JAM_IDX_W-1:0]          owner_q, owner_d;
  logic [JAM_IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]              lock_cnt_q, lock_cnt_d;
  logic [JAM_IDX_W-1:0]          w_q, w_d, j_q, j_d;
  logic [ROM_LAT:0]              tag_vld_q, tag_vld_d;
  logic [ROM_LAT:0][JAM_IDX_W-1:0] tag_id_q, tag_id_d;
  logic                          rsp_vld_q, rsp_vld_d;
  logic [JAM_IDX_W-1:0]          rsp_id_q, rsp_id_d;
  logic [JAM_COST_W-1:0]         rsp_cost_q, rsp_cost_d;

  logic                          locked;
  logic [NREQ-1:0]               fire;
  logic                          any_fire;
  logic                          fire_lock;
  logic [JAM_IDX_W-1:0]          fire_id, fire_w, fire_j;

  assign locked = (state_q == LK_LOCKED);

  jam_rr_picker #(.NREQ(NREQ)) u_picker (
    .req      (req_valid),
    .rr_ptr   (rr_ptr_q),
    .force_en (locked),
    .force_id (owner_q),
    .grant    (req_ready)
  );

  always_comb begin
    fire      = req_valid & req_ready;
    any_fire  = |fire;
    fire_lock = |(fire & req_lock);
    fire_id   = '0;
    fire_w    = '0;
    fire_j    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (fire[i]) begin
        fire_id = JAM_IDX_W'(i);
        fire_w  = req_w[3*i +: 3];
        fire_j  = req_j[3*i +: 3];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      LK_UNLOCKED: begin
        if (any_fire) begin
          if (fire_lock) begin
            state_d    = LK_LOCKED;
            owner_d    = fire_id;
            lock_cnt_d = CNT_W'(1);
          end else begin
            rr_ptr_d = jam_inc_mod(fire_id, NREQ);
          end
        end
      end
      LK_LOCKED: begin
        // lock_cnt counts grants already taken in this lock; the LOCK_MAX-th grant always releases.
        if (any_fire) begin
          if (fire_lock && (lock_cnt_q < CNT_W'(LOCK_MAX - 1))) begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
          end else begin
            state_d    = LK_UNLOCKED;
            lock_cnt_d = '0;
            rr_ptr_d   = jam_inc_mod(fire_id, NREQ);
          end
        end
      end
      default: state_d = LK_UNLOCKED;
    endcase
  end

  always_comb begin
    w_d          = any_fire ? fire_w : w_q;
    j_d          = any_fire ? fire_j : j_q;
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = any_fire;
    tag_id_d[0]  = fire_id;
    for (int k = 1; k <= ROM_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
    rsp_vld_d  = tag_vld_q[ROM_LAT];
    rsp_id_d   = rsp_id_q;
    rsp_cost_d = rsp_cost_q;
    if (tag_vld_q[ROM_LAT]) begin
      rsp_id_d   = tag_id_q[ROM_LAT];
      rsp_cost_d = Cost;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= LK_UNLOCKED;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      lock_cnt_q <= '0;
      w_q        <= '0;
      j_q        <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_cost_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      w_q        <= w_d;
      j_q        <= j_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_id_q   <= rsp_id_d;
      rsp_cost_q <= rsp_cost_d;
    end
  end

  assign W         = w_q;
  assign J         = j_q;
  assign rsp_valid = rsp_vld_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_cost  = rsp_cost_q;

endmodule
